bk_mouse_port: RTL and testbench
================================

# bk_mouse_port

Mouse adapter for the BK parallel port (177714). Consumes per-packet pointer deltas and button state from the PS/2 mouse decoder, accumulates movement, converts it into the BK direction/button bit format, and serves it on the port read path. It also performs the joystick/mouse source arbitration, so its `bus_dout` replaces the top-level `port_data` mux.

## Interface
Parameters:
- `THRESH`, 3: movement magnitude (counts) that must be exceeded to assert a direction bit.
- `HOLD_TICKS`, 16'd4096: `ce` ticks a direction bit stays set before auto-clear (see Configuration).

Ports:
- `clk_sys`  in  1: system clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `ce`  in  1: tick enable for the hold timer (`ce_12mp` at top level).
- `data_ready`  in  1: one-cycle pulse, new mouse packet valid.
- `pointer_dx`  in  9: two's-complement X delta, +right.
- `pointer_dy`  in  9: two's-complement Y delta.
- `left_btn`, `right_btn`  in  1 each: button levels.
- `joystick`  in  8: OR of both joysticks.
- `port_sel`, `bus_stb`, `bus_we`  in  1 each: CPU port select, strobe, write.
- `bus_wtbt`  in  2: byte-enable; bit 0 = low byte.
- `bus_din`  in  16: CPU write data.
- `bus_dout`  out  16: port read data; 0 when `port_sel` low.
- `mouse_active`  out  1: 1 = mouse is the port source.

## Operation
- Register `mstate[6:0]`: bit0 Y+, bit1 X+, bit2 Y−, bit3 X−, bit5 left, bit6 right, bit4 always 0.
- Control write = rising edge of `bus_stb & port_sel & bus_we & bus_wtbt[0]`. On it: `enable <= bus_din[3]`; if `bus_din[3]==0`, clear `mstate[3:0]`, both accumulators, and both hold timers.
- Accumulators `acc_x`, `acc_y`: 12-bit signed. When `enable & data_ready`, add sign-extended delta, saturating at +2047 / −2048.
- Per-axis FSM, IDLE/HELD:
  - IDLE→HELD when `acc > THRESH`, setting the + bit, or when `acc < −THRESH`, setting the − bit.
  - On the transition: zero that accumulator and load the hold timer with `HOLD_TICKS`.
  - In HELD the opposite bit of the same axis is never set. The accumulator keeps integrating, saturating.
  - HELD→IDLE on a clearing control write or on hold expiry; the bit is cleared.
- Buttons: `mstate[6:5] <= {right_btn, left_btn}` every cycle, independent of `enable`.
- Source arbitration: `mouse_active <= 1` on `data_ready`; `<= 0` when `joystick != 0`. If both occur in the same cycle, joystick wins.
- `bus_dout = port_sel ? (mouse_active ? {9'b0, mstate} : {8'b0, joystick}) : 16'd0`, combinational from registers.
- Writes with `bus_wtbt[0]==0` are ignored.

## Timing
- Reset values: `mstate=0`, `enable=0`, accumulators 0, FSMs IDLE, timers 0, `mouse_active=0`, so `bus_dout=0`.
- Write edge detector uses one register. State changes 1 cycle after `bus_stb` rises. A strobe held high counts once.
- `data_ready` → accumulator updated next cycle → direction bit visible 1 cycle after that (2-cycle latency).
- Control write and `data_ready` in the same cycle: the write is applied and the packet is discarded.
- Hold timer decrements only on `ce`. The bit clears on the cycle the timer reaches 0.
- Reset asserted mid-hold or mid-packet: all state returns to reset values on the next edge. No partial update survives.

## Configuration
- `BK_MOUSE_AUTOCLEAR_EN`:
  - Defined: hold timers are present, and HELD→IDLE also occurs on timer expiry.
  - Undefined: timers are omitted (`HOLD_TICKS` unused), and direction bits clear only on a control write with `bus_din[3]==0` or on reset.

## Test plan
- Reset, then read with `port_sel=1`: `bus_dout == 16'h0000` and `mouse_active == 0`.
- Write `0x0008`, then pulse `data_ready` with dx=+2 twice: after the second packet `mstate[1]==1` (acc 4 > 3), and `bus_dout == 16'h0002`.
- Enabled, pulse dy=−2 then dy=−2: `mstate[2]==1`. A following dy=+9 does not set bit0. Write `0x0000`: bits [3:0] clear to 0.
- Buttons left=1, right=1 with `enable=0` and `mouse_active=1`: `bus_dout == 16'h0060`. Then `joystick=8'h04`: `bus_dout == 16'h0004` and `mouse_active==0`.
- Control write `0x0000` in the same cycle as `data_ready` with dx=+100: no direction bit is set, and `acc_x==0`.
- With `BK_MOUSE_AUTOCLEAR_EN` defined and `HOLD_TICKS=4`: X+ asserted, 4 `ce` pulses later bit1 = 0. With the macro undefined, bit1 is still 1 after 10000 `ce` pulses.

Source files
------------

// File: rtl/bk_mouse_port.sv
// BK parallel-port (177714) mouse adapter: accumulates PS/2 deltas into BK direction/button bits
// and arbitrates the port read data between mouse and joystick. Optional macro: BK_MOUSE_AUTOCLEAR_EN.
module bk_mouse_port #(
  parameter int          THRESH     = 3,
  parameter logic [15:0] HOLD_TICKS = 16'd4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        data_ready,
  input  logic [8:0]  pointer_dx,
  input  logic [8:0]  pointer_dy,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic [7:0]  joystick,
  input  logic        port_sel,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        mouse_active
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} axis_state_e;

  localparam logic signed [11:0] THR_P = 12'(THRESH);
  localparam logic signed [11:0] THR_N = -THR_P;

  function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic signed [8:0]  d);
    logic signed [12:0] s;
    s = {a[11], a} + {{4{d[8]}}, d};
    if (s[12] != s[11]) return s[12] ? 12'sh800 : 12'sh7FF;
    return s[11:0];
  endfunction

  logic               wr_q, wr_d;
  logic               enable_q, enable_d;
  logic signed [11:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  axis_state_e        xs_q, xs_d, ys_q, ys_d;
  logic               xpos_q, xpos_d, ypos_q, ypos_d;
  logic [1:0]         btn_q, btn_d;
  logic               mact_q, mact_d;
  logic               wr_edge, pkt;
  logic signed [11:0] base_x, base_y;
  logic [6:0]         mstate;
  logic               unused_bits;

`ifdef BK_MOUSE_AUTOCLEAR_EN
  logic [15:0] tmr_x_q, tmr_x_d, tmr_y_q, tmr_y_d;
  assign unused_bits = ^{bus_din[15:4], bus_din[2:0], bus_wtbt[1]};
`else
  assign unused_bits = ^{bus_din[15:4], bus_din[2:0], bus_wtbt[1], HOLD_TICKS, ce};
`endif

  assign wr_d    = bus_stb & port_sel & bus_we & bus_wtbt[0];
  assign wr_edge = wr_d & ~wr_q;
  // A control write in the same cycle as a packet wins; the packet is dropped.
  assign pkt     = data_ready & enable_q & ~wr_edge;

  always_comb begin
    enable_d = enable_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    base_x   = acc_x_q;
    base_y   = acc_y_q;
`ifdef BK_MOUSE_AUTOCLEAR_EN
    tmr_x_d  = tmr_x_q;
    tmr_y_d  = tmr_y_q;
`endif

    if (xs_q == IDLE) begin
      if (acc_x_q > THR_P || acc_x_q < THR_N) begin
        xs_d   = HELD;
        xpos_d = (acc_x_q > THR_P);
        base_x = '0;
`ifdef BK_MOUSE_AUTOCLEAR_EN
        tmr_x_d = HOLD_TICKS;
`endif
      end
    end else begin
`ifdef BK_MOUSE_AUTOCLEAR_EN
      if (ce) begin
        if (tmr_x_q <= 16'd1) begin
          xs_d    = IDLE;
          tmr_x_d = '0;
        end else begin
          tmr_x_d = tmr_x_q - 16'd1;
        end
      end
`endif
    end

    if (ys_q == IDLE) begin
      if (acc_y_q > THR_P || acc_y_q < THR_N) begin
        ys_d   = HELD;
        ypos_d = (acc_y_q > THR_P);
        base_y = '0;
`ifdef BK_MOUSE_AUTOCLEAR_EN
        tmr_y_d = HOLD_TICKS;
`endif
      end
    end else begin
`ifdef BK_MOUSE_AUTOCLEAR_EN
      if (ce) begin
        if (tmr_y_q <= 16'd1) begin
          ys_d    = IDLE;
          tmr_y_d = '0;
        end else begin
          tmr_y_d = tmr_y_q - 16'd1;
        end
      end
`endif
    end

    acc_x_d = pkt ? sat_add(base_x, pointer_dx) : base_x;
    acc_y_d = pkt ? sat_add(base_y, pointer_dy) : base_y;

    if (wr_edge) begin
      enable_d = bus_din[3];
      if (!bus_din[3]) begin
        xs_d    = IDLE;
        ys_d    = IDLE;
        acc_x_d = '0;
        acc_y_d = '0;
`ifdef BK_MOUSE_AUTOCLEAR_EN
        tmr_x_d = '0;
        tmr_y_d = '0;
`endif
      end
    end

    btn_d = {right_btn, left_btn};
    // Joystick activity takes priority over a simultaneous mouse packet.
    if (joystick != 8'd0)  mact_d = 1'b0;
    else if (data_ready)   mact_d = 1'b1;
    else                   mact_d = mact_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q     <= 1'b0;
      enable_q <= 1'b0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      xs_q     <= IDLE;
      ys_q     <= IDLE;
      xpos_q   <= 1'b0;
      ypos_q   <= 1'b0;
      btn_q    <= '0;
      mact_q   <= 1'b0;
`ifdef BK_MOUSE_AUTOCLEAR_EN
      tmr_x_q  <= '0;
      tmr_y_q  <= '0;
`endif
    end else begin
      wr_q     <= wr_d;
      enable_q <= enable_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      btn_q    <= btn_d;
      mact_q   <= mact_d;
`ifdef BK_MOUSE_AUTOCLEAR_EN
      tmr_x_q  <= tmr_x_d;
      tmr_y_q  <= tmr_y_d;
`endif
    end
  end

  assign mstate = {btn_q[1], btn_q[0], 1'b0,
                   (xs_q == HELD) & ~xpos_q, (ys_q == HELD) & ~ypos_q,
                   (xs_q == HELD) &  xpos_q, (ys_q == HELD) &  ypos_q};

  assign mouse_active = mact_q;
  assign bus_dout = port_sel ? (mact_q ? {9'b0, mstate} : {8'b0, joystick}) : 16'd0;

endmodule

// File: tb/tb_bk_mouse_port.sv
// Directed self-checking bench for bk_mouse_port (HOLD_TICKS=4 so the auto-clear build is quick).
module tb_bk_mouse_port;
  logic        clk_sys = 1'b0;
  logic        reset, ce, data_ready, left_btn, right_btn;
  logic [8:0]  pointer_dx, pointer_dy;
  logic [7:0]  joystick;
  logic        port_sel, bus_stb, bus_we;
  logic [1:0]  bus_wtbt;
  logic [15:0] bus_din, bus_dout;
  logic        mouse_active;
  int          total = 0;
  int          bad = 0;

  bk_mouse_port #(.THRESH(3), .HOLD_TICKS(16'd4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .data_ready(data_ready),
    .pointer_dx(pointer_dx), .pointer_dy(pointer_dy),
    .left_btn(left_btn), .right_btn(right_btn), .joystick(joystick),
    .port_sel(port_sel), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_wtbt(bus_wtbt), .bus_din(bus_din), .bus_dout(bus_dout),
    .mouse_active(mouse_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic write_ctl(input logic [15:0] d, input logic [1:0] be = 2'b01);
    bus_din = d; bus_wtbt = be; bus_we = 1'b1; bus_stb = 1'b1;
    cyc();
    bus_stb = 1'b0; bus_we = 1'b0;
    cyc();
  endtask

  task automatic packet(input logic [8:0] dx, input logic [8:0] dy);
    pointer_dx = dx; pointer_dy = dy; data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; data_ready = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
    pointer_dx = '0; pointer_dy = '0; joystick = '0; port_sel = 1'b1;
    bus_stb = 1'b0; bus_we = 1'b0; bus_wtbt = 2'b00; bus_din = '0;
    cyc(2);
    reset = 1'b0;
    cyc();
    check("reset_dout", bus_dout, 16'h0000);
    check("reset_mact", {15'd0, mouse_active}, 16'h0001 ^ 16'h0001);

    // X+ after two +2 packets
    write_ctl(16'h0008);
    packet(9'd2, 9'd0);
    check("x_below_thresh", bus_dout, 16'h0000);
    packet(9'd2, 9'd0);
    check("x_plus", bus_dout, 16'h0002);
    check("mact_on_pkt", {15'd0, mouse_active}, 16'h0001);

    // Y- then opposite-direction delta while held
    packet(9'h1FE, 9'h1FE);
    packet(9'd0, 9'h1FE);
    check("y_minus", bus_dout, 16'h0006);
    packet(9'd0, 9'd9);
    check("y_held_no_opposite", bus_dout, 16'h0006);
    check("acc_y_integrates", {4'h0, dut.acc_y_q}, 16'h0009);
    write_ctl(16'h0000, 2'b00);
    check("wtbt0_ignored", bus_dout, 16'h0006);
    write_ctl(16'h0000);
    check("clear_write", bus_dout, 16'h0000);

    // Buttons with enable=0; packets ignored for movement
    left_btn = 1'b1; right_btn = 1'b1;
    packet(9'd50, 9'd0);
    check("buttons", bus_dout, 16'h0060);
    check("acc_x_disabled", {4'h0, dut.acc_x_q}, 16'h0000);
    joystick = 8'h04;
    cyc();
    check("joy_dout", bus_dout, 16'h0004);
    check("joy_mact", {15'd0, mouse_active}, 16'h0000);
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    check("joy_wins", {15'd0, mouse_active}, 16'h0000);
    joystick = 8'h00;
    packet(9'd0, 9'd0);
    check("mact_back", {15'd0, mouse_active}, 16'h0001);
    port_sel = 1'b0;
    #1;
    check("port_unsel", bus_dout, 16'h0000);
    port_sel = 1'b1;
    left_btn = 1'b0; right_btn = 1'b0;

    // Control write collides with a packet: packet discarded
    write_ctl(16'h0008);
    bus_din = 16'h0000; bus_wtbt = 2'b01; bus_we = 1'b1; bus_stb = 1'b1;
    pointer_dx = 9'd100; data_ready = 1'b1;
    cyc();
    data_ready = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
    cyc(2);
    check("collide_dout", bus_dout, 16'h0000);
    check("collide_acc", {4'h0, dut.acc_x_q}, 16'h0000);

    // Held strobe counts once: a packet during the held strobe is kept
    bus_din = 16'h0008; bus_wtbt = 2'b01; bus_we = 1'b1; bus_stb = 1'b1;
    cyc(3);
    pointer_dx = 9'd5; data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    cyc(2);
    bus_stb = 1'b0; bus_we = 1'b0;
    cyc();
    check("held_strobe_once", bus_dout, 16'h0002);

    // Saturation while held
    for (int i = 0; i < 10; i++) packet(9'd255, 9'h100);
    check("sat_pos", {4'h0, dut.acc_x_q}, 16'h07FF);
    check("sat_neg", {4'h0, dut.acc_y_q}, 16'h0800);
    check("sat_bits", bus_dout, 16'h0006);

    // Reset mid-hold
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    check("reset_mid_dout", bus_dout, 16'h0000);
    check("reset_mid_acc", {4'h0, dut.acc_x_q}, 16'h0000);

    // Hold timer
    write_ctl(16'h0008);
    packet(9'd5, 9'd0);
    check("timer_set", bus_dout, 16'h0002);
`ifdef BK_MOUSE_AUTOCLEAR_EN
    for (int i = 0; i < 3; i++) begin
      ce = 1'b1; cyc(); ce = 1'b0; cyc();
    end
    check("timer_3ce_hold", bus_dout, 16'h0002);
    ce = 1'b1; cyc(); ce = 1'b0;
    check("timer_expire", bus_dout, 16'h0000);
`else
    ce = 1'b1;
    cyc(10000);
    ce = 1'b0;
    check("no_autoclear", bus_dout, 16'h0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
